// File: rtl/z80_bitop_pkg.sv
// Shared definitions for the indexed bit-operation unit: flag bit positions,
// CB-page op-group encodings, FSM state type and architectural T-state counts.
package z80_bitop_pkg;

    // Flag register bit positions (S Z F5 H F3 P/V N C).
    localparam int FLAG_S  = 7;
    localparam int FLAG_Z  = 6;
    localparam int FLAG_F5 = 5;
    localparam int FLAG_H  = 4;
    localparam int FLAG_F3 = 3;
    localparam int FLAG_PV = 2;
    localparam int FLAG_N  = 1;
    localparam int FLAG_C  = 0;

    // CB-page op groups (op[7:6]).
    localparam logic [1:0] GG_ROT = 2'b00;
    localparam logic [1:0] GG_BIT = 2'b01;
    localparam logic [1:0] GG_RES = 2'b10;
    localparam logic [1:0] GG_SET = 2'b11;

    // Register field value meaning "(HL)/(IX+d)" i.e. memory only.
    localparam logic [2:0] R_MEM = 3'd6;

    // Architectural T-state counts reported on completion.
    localparam logic [4:0] TSTATES_BIT    = 5'd20;
    localparam logic [4:0] TSTATES_RESSET = 5'd23;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_READ  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } bitop_state_e;

endpackage

// File: rtl/z80_bitop_alu.sv
// Combinational core of BIT/RES/SET: produces the modified byte and the
// BIT flag set from the fetched operand, the bit index and the entry flags.
module z80_bitop_alu
    import z80_bitop_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter bit XY_FROM_EA = 1'b0
) (
    input  logic [1:0]        gg,
    input  logic [2:0]        bit_idx,
    input  logic [7:0]        rdata,
    input  logic [7:0]        f_in,
    input  logic [ADDR_W-1:0] ea,
    output logic [7:0]        result,
    output logic [7:0]        flags
);

    logic [7:0] mask;
    logic       tested;
    logic       ea_unused;

    // Only EA[13]/EA[11] feed the flags; the remaining bits are intentionally dropped.
    assign ea_unused = ^ea;

    // Bit mask, result byte and flag generation for the selected group.
    always_comb begin
        mask   = 8'd1 << bit_idx;
        tested = |(rdata & mask);
        result = rdata;
        flags  = f_in;
        case (gg)
            GG_BIT: begin
                flags[FLAG_S]  = (bit_idx == 3'd7) & rdata[7];
                flags[FLAG_Z]  = ~tested;
                flags[FLAG_PV] = ~tested;
                flags[FLAG_H]  = 1'b1;
                flags[FLAG_N]  = 1'b0;
                flags[FLAG_C]  = f_in[FLAG_C];
                if (XY_FROM_EA) begin
                    flags[FLAG_F5] = ea[13];
                    flags[FLAG_F3] = ea[11];
                end
            end
            GG_RES:  result = rdata & ~mask;
            GG_SET:  result = rdata | mask;
            default: ;
        endcase
    end

endmodule

// File: rtl/z80_idx_bitop_unit.sv
// Sequencer for DD/FD CB d op: computes the indexed effective address, reads
// the operand, runs BIT/RES/SET and writes RES/SET results back to memory.
// Bus handshake: mem_rd/mem_wr (with mem_addr/mem_wdata) are held stable until
// a cycle in which mem_ack=1; that cycle completes the request and mem_rdata is
// sampled in it. mem_ack is ignored when no request is outstanding.
module z80_idx_bitop_unit
    import z80_bitop_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter bit UNDOC_COPY = 1'b1,
    parameter bit XY_FROM_EA = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        op,
    input  logic [7:0]        disp,
    input  logic              iy,
    input  logic [ADDR_W-1:0] ix_in,
    input  logic [ADDR_W-1:0] iy_in,
    input  logic [7:0]        f_in,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        f_out,
    output logic              f_we,
    output logic              reg_we,
    output logic [2:0]        reg_sel,
    output logic [7:0]        reg_wdata,
    output logic [4:0]        tstates,
    output bitop_state_e      dbg_state
);

    bitop_state_e      state, state_nx;
    logic [7:0]        op_q;
    logic [7:0]        disp_q;
    logic [ADDR_W-1:0] idx_q;
    logic [7:0]        f_q;
    logic [ADDR_W-1:0] ea_q;
    logic [7:0]        rdata_q;
    logic              err_q;
    logic [7:0]        alu_result;
    logic [7:0]        alu_flags;

    assign dbg_state = state;

    z80_bitop_alu #(
        .ADDR_W     (ADDR_W),
        .XY_FROM_EA (XY_FROM_EA)
    ) u_alu (
        .gg      (op_q[7:6]),
        .bit_idx (op_q[5:3]),
        .rdata   (rdata_q),
        .f_in    (f_q),
        .ea      (ea_q),
        .result  (alu_result),
        .flags   (alu_flags)
    );

    // State register plus operand, address and read-data latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            disp_q  <= '0;
            idx_q   <= '0;
            f_q     <= '0;
            ea_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        disp_q <= disp;
                        idx_q  <= iy ? iy_in : ix_in;
                        f_q    <= f_in;
                        err_q  <= (op[7:6] == GG_ROT);
                    end
                end
                // Displacement is signed; the sum wraps modulo 2^ADDR_W.
                ST_ADDR: ea_q <= idx_q + {{(ADDR_W-8){disp_q[7]}}, disp_q};
                ST_READ: if (mem_ack) rdata_q <= mem_rdata;
                default: ;
            endcase
        end
    end

    // Next-state logic and all outputs, decoded from the current state.
    always_comb begin
        state_nx  = state;
        busy      = (state != ST_IDLE);
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = 1'b0;
        err       = 1'b0;
        f_out     = '0;
        f_we      = 1'b0;
        reg_we    = 1'b0;
        reg_sel   = '0;
        reg_wdata = '0;
        tstates   = '0;
        case (state)
            ST_IDLE: begin
                if (start) state_nx = (op[7:6] == GG_ROT) ? ST_DONE : ST_ADDR;
            end
            ST_ADDR: state_nx = ST_READ;
            ST_READ: begin
                mem_rd   = 1'b1;
                mem_addr = ea_q;
                if (mem_ack) state_nx = ST_EXEC;
            end
            ST_EXEC: state_nx = (op_q[7:6] == GG_BIT) ? ST_DONE : ST_WRITE;
            ST_WRITE: begin
                mem_wr    = 1'b1;
                mem_addr  = ea_q;
                mem_wdata = alu_result;
                if (mem_ack) state_nx = ST_DONE;
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
                done     = 1'b1;
                err      = err_q;
                f_out    = f_q;
                if (!err_q) begin
                    if (op_q[7:6] == GG_BIT) begin
                        f_out   = alu_flags;
                        f_we    = 1'b1;
                        tstates = TSTATES_BIT;
                    end else begin
                        tstates = TSTATES_RESSET;
                        // Undocumented copy of the RES/SET result into register r.
                        if (UNDOC_COPY && (op_q[2:0] != R_MEM)) begin
                            reg_we    = 1'b1;
                            reg_sel   = op_q[2:0];
                            reg_wdata = alu_result;
                        end
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_z80_idx_bitop_unit.sv
// Bench for z80_idx_bitop_unit: directed operations with hand-computed results,
// an expected queue filled by the driver and drained by a done monitor, plus a
// memory responder with programmable acknowledge delay.
`timescale 1ns/1ps
module tb_z80_idx_bitop_unit;
    import z80_bitop_pkg::*;

    typedef struct {
        logic        err;
        logic [7:0]  f_out;
        logic        f_we;
        logic        reg_we;
        logic [2:0]  reg_sel;
        logic [7:0]  reg_wdata;
        logic [4:0]  tstates;
        int          rd_n;
        logic [15:0] rd_addr;
        int          wr_n;
        logic [15:0] wr_addr;
        logic [7:0]  wr_data;
        int          lat;
        int          start_cyc;
    } exp_t;

    // ---------------- clock / reset / stimulus signals ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start_x = 1'b0;
    logic [7:0]  op = 8'h00;
    logic [7:0]  disp = 8'h00;
    logic        iy = 1'b0;
    logic [15:0] ix_in = 16'h0000;
    logic [15:0] iy_in = 16'h0000;
    logic [7:0]  f_in = 8'h00;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;

    logic        mem_rd, mem_wr, busy, done, err, f_we, reg_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, f_out, reg_wdata;
    logic [2:0]  reg_sel;
    logic [4:0]  tstates;
    bitop_state_e dbg_state;

    logic        mem_rd_x, mem_wr_x, busy_x, done_x, err_x, f_we_x, reg_we_x;
    logic [15:0] mem_addr_x;
    logic [7:0]  mem_wdata_x, f_out_x, reg_wdata_x, mem_rdata_x;
    logic [2:0]  reg_sel_x;
    logic [4:0]  tstates_x;
    logic        mem_ack_x;
    bitop_state_e dbg_state_x;

    logic [7:0]  mem [0:65535];
    exp_t        exp_q[$];
    exp_t        exp_x_q[$];
    exp_t        mon_e;
    exp_t        mon_x;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_x_cnt = 0;
    int ack_delay = 0;

    // bus monitor state
    int          ack_cnt = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [15:0] rd_addr_seen = 0;
    logic [15:0] wr_addr_seen = 0;
    logic [7:0]  wr_data_seen = 0;
    logic        req_open = 0;
    logic [15:0] req_addr = 0;
    logic [7:0]  req_wdata = 0;
    logic        req_wr = 0;
    logic        unstable = 0;
    logic        both_seen = 0;

    assign mem_ack_x   = 1'b1;
    assign mem_rdata_x = (mem_addr_x == 16'h2800) ? 8'h01 : 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    z80_idx_bitop_unit #(.ADDR_W(16), .UNDOC_COPY(1'b1), .XY_FROM_EA(1'b0)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .disp(disp), .iy(iy),
        .ix_in(ix_in), .iy_in(iy_in), .f_in(f_in),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .done(done), .err(err), .f_out(f_out), .f_we(f_we),
        .reg_we(reg_we), .reg_sel(reg_sel), .reg_wdata(reg_wdata), .tstates(tstates),
        .dbg_state(dbg_state)
    );

    z80_idx_bitop_unit #(.ADDR_W(16), .UNDOC_COPY(1'b1), .XY_FROM_EA(1'b1)) u_dut_xy (
        .clk(clk), .reset(reset), .start(start_x), .op(op), .disp(disp), .iy(iy),
        .ix_in(ix_in), .iy_in(iy_in), .f_in(f_in),
        .mem_rd(mem_rd_x), .mem_wr(mem_wr_x), .mem_addr(mem_addr_x), .mem_wdata(mem_wdata_x),
        .mem_rdata(mem_rdata_x), .mem_ack(mem_ack_x),
        .busy(busy_x), .done(done_x), .err(err_x), .f_out(f_out_x), .f_we(f_we_x),
        .reg_we(reg_we_x), .reg_sel(reg_sel_x), .reg_wdata(reg_wdata_x), .tstates(tstates_x),
        .dbg_state(dbg_state_x)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic exp_t mk(input logic e_err, input logic [7:0] fo, input logic fwe,
                                input logic rwe, input logic [2:0] rs, input logic [7:0] rwd,
                                input logic [4:0] ts, input int rdn, input logic [15:0] ra,
                                input int wrn, input logic [15:0] wa, input logic [7:0] wd,
                                input int lat);
        exp_t e;
        e.err = e_err; e.f_out = fo; e.f_we = fwe; e.reg_we = rwe; e.reg_sel = rs;
        e.reg_wdata = rwd; e.tstates = ts; e.rd_n = rdn; e.rd_addr = ra; e.wr_n = wrn;
        e.wr_addr = wa; e.wr_data = wd; e.lat = lat; e.start_cyc = 0;
        return e;
    endfunction

    task automatic clear_bus_stats();
        rd_cnt = 0; wr_cnt = 0; unstable = 0; both_seen = 0;
    endtask

    // ---------------- memory responder + scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            mem_ack = 1'b0;
            ack_cnt = 0;
            req_open = 1'b0;
            clear_bus_stats();
        end else begin
            if (mem_ack) begin
                mem_ack = 1'b0;
                req_open = 1'b0;
            end
            if (mem_rd && mem_wr) both_seen = 1'b1;
            if (mem_rd || mem_wr) begin
                if (req_open) begin
                    if (mem_addr != req_addr || mem_wdata != req_wdata || mem_wr != req_wr)
                        unstable = 1'b1;
                end else begin
                    req_open = 1'b1;
                    req_addr = mem_addr; req_wdata = mem_wdata; req_wr = mem_wr;
                    if (mem_rd) begin rd_cnt++; rd_addr_seen = mem_addr; end
                    else begin wr_cnt++; wr_addr_seen = mem_addr; wr_data_seen = mem_wdata; end
                end
                if (ack_cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    ack_cnt = 0;
                    if (mem_rd) mem_rdata = mem[mem_addr];
                end else begin
                    ack_cnt++;
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("latency", cyc - mon_e.start_cyc, mon_e.lat);
                    chk("busy_in_done", busy, 1'b1);
                    chk("err", err, mon_e.err);
                    chk("f_out", f_out, mon_e.f_out);
                    chk("f_we", f_we, mon_e.f_we);
                    chk("reg_we", reg_we, mon_e.reg_we);
                    if (mon_e.reg_we) begin
                        chk("reg_sel", reg_sel, mon_e.reg_sel);
                        chk("reg_wdata", reg_wdata, mon_e.reg_wdata);
                    end
                    chk("tstates", tstates, mon_e.tstates);
                    chk("rd_count", rd_cnt, mon_e.rd_n);
                    if (mon_e.rd_n > 0) chk("rd_addr", rd_addr_seen, mon_e.rd_addr);
                    chk("wr_count", wr_cnt, mon_e.wr_n);
                    if (mon_e.wr_n > 0) begin
                        chk("wr_addr", wr_addr_seen, mon_e.wr_addr);
                        chk("wr_data", wr_data_seen, mon_e.wr_data);
                    end
                    chk("bus_stable", unstable, 1'b0);
                    chk("rd_wr_overlap", both_seen, 1'b0);
                    chk("strobe_in_done", {mem_rd, mem_wr}, 2'b00);
                end
                done_cnt++;
                clear_bus_stats();
            end
            if (done_x) begin
                if (exp_x_q.size() == 0) begin
                    chk("xy_unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_x = exp_x_q.pop_front();
                    chk("xy_latency", cyc - mon_x.start_cyc, mon_x.lat);
                    chk("xy_f_out", f_out_x, mon_x.f_out);
                    chk("xy_f_we", f_we_x, mon_x.f_we);
                    chk("xy_tstates", tstates_x, mon_x.tstates);
                end
                done_x_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic scramble();
        op = 8'($urandom); disp = 8'($urandom); iy = 1'($urandom_range(0, 1));
        ix_in = 16'($urandom); iy_in = 16'($urandom); f_in = 8'($urandom);
    endtask

    task automatic wait_count(input int target, input bit xy);
        bit got = 0;
        for (int k = 0; k < 80; k++) begin
            #1;
            if ((xy ? done_x_cnt : done_cnt) >= target) begin got = 1; break; end
            @(negedge clk);
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic issue(input logic [7:0] o, input logic [7:0] d, input logic sel,
                         input logic [15:0] ixv, input logic [15:0] iyv, input logic [7:0] f,
                         input exp_t e_in, input int pulses);
        exp_t e;
        int target;
        e = e_in;
        op = o; disp = d; iy = sel; ix_in = ixv; iy_in = iyv; f_in = f;
        start = 1'b1;
        e.start_cyc = cyc;
        exp_q.push_back(e);
        target = done_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        scramble();
        for (int k = 0; k < pulses; k++) begin
            start = 1'b1;
            scramble();
            @(negedge clk);
        end
        start = 1'b0;
        wait_count(target, 1'b0);
    endtask

    task automatic issue_xy(input logic [7:0] o, input logic [7:0] d, input logic [15:0] ixv,
                            input logic [7:0] f, input exp_t e_in);
        exp_t e;
        int target;
        e = e_in;
        op = o; disp = d; iy = 1'b0; ix_in = ixv; f_in = f;
        start_x = 1'b1;
        e.start_cyc = cyc;
        exp_x_q.push_back(e);
        target = done_x_cnt + 1;
        @(negedge clk);
        start_x = 1'b0;
        scramble();
        wait_count(target, 1'b1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int  d0;
        bit  seen_wr;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ctrl", {busy, done, err, mem_rd, mem_wr, f_we, reg_we}, 7'd0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        chk("rst_f_out", f_out, 8'h00);
        chk("rst_reg", {reg_sel, reg_wdata}, 11'd0);
        chk("rst_tstates", tstates, 5'd0);
        chk("rst_state", dbg_state, ST_IDLE);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // BIT 7,(IX+5): bit set -> S=1 Z=0; F5/F3/C pass from f_in=29
        mem[16'h1005] = 8'h80;
        issue(8'h7E, 8'h05, 1'b0, 16'h1000, 16'h7777, 8'h29,
              mk(0, 8'hB9, 1, 0, 0, 0, 5'd20, 1, 16'h1005, 0, 0, 0, 4), 0);
        // SET 3,(IY-2): selects IY, negative displacement
        mem[16'h1FFE] = 8'h00;
        issue(8'hDE, 8'hFE, 1'b1, 16'h5555, 16'h2000, 8'h42,
              mk(0, 8'h42, 0, 0, 0, 0, 5'd23, 1, 16'h1FFE, 1, 16'h1FFE, 8'h08, 5), 0);
        // RES 0,(IX+1),B: EA wraps FFFF+1 -> 0000, copy to B
        mem[16'h0000] = 8'hFF;
        issue(8'h80, 8'h01, 1'b0, 16'hFFFF, 16'h0000, 8'h13,
              mk(0, 8'h13, 0, 1, 3'd0, 8'hFE, 5'd23, 1, 16'h0000, 1, 16'h0000, 8'hFE, 5), 0);
        // BIT 3,(IX-128): tested bit clear -> Z=PV=1, S=0 although bit7=1
        mem[16'h0080] = 8'hF7;
        issue(8'h5E, 8'h80, 1'b0, 16'h0100, 16'h0000, 8'h01,
              mk(0, 8'h55, 1, 0, 0, 0, 5'd20, 1, 16'h0080, 0, 0, 0, 4), 0);
        // SET 7,(IX+10),A: copy to A (r=7)
        mem[16'h4010] = 8'h01;
        issue(8'hFF, 8'h10, 1'b0, 16'h4000, 16'h0000, 8'h00,
              mk(0, 8'h00, 0, 1, 3'd7, 8'h81, 5'd23, 1, 16'h4010, 1, 16'h4010, 8'h81, 5), 0);
        // Rotate group -> immediate error completion, back-to-back
        issue(8'h06, 8'h33, 1'b0, 16'h1234, 16'h0000, 8'h5A,
              mk(1, 8'h5A, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1), 0);
        issue(8'h3F, 8'h00, 1'b1, 16'h0000, 16'h1234, 8'hC3,
              mk(1, 8'hC3, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 1), 0);

        // Delayed acknowledge with start pulses through every busy state
        ack_delay = 3;
        mem[16'h12B3] = 8'hFF;
        issue(8'hAB, 8'h7F, 1'b1, 16'h0000, 16'h1234, 8'h80,
              mk(0, 8'h80, 0, 1, 3'd3, 8'hDF, 5'd23, 1, 16'h12B3, 1, 16'h12B3, 8'hDF, 11), 11);
        mem[16'h3000] = 8'h7F;
        issue(8'h7E, 8'h00, 1'b0, 16'h3000, 16'h0000, 8'hFE,
              mk(0, 8'h7C, 1, 0, 0, 0, 5'd20, 1, 16'h3000, 0, 0, 0, 7), 7);

        // Reset asserted while WRITE is outstanding
        mem[16'h0300] = 8'h00;
        op = 8'hDE; disp = 8'h00; iy = 1'b0; ix_in = 16'h0300; f_in = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen_wr = 1'b0;
        for (int k = 0; k < 30; k++) begin
            #1;
            if (mem_wr) begin seen_wr = 1'b1; break; end
            @(negedge clk);
        end
        chk("abort_reached_write", seen_wr, 1'b1);
        d0 = done_cnt;
        #1 reset = 1'b1;
        #1;
        chk("abort_mem_wr_low", mem_wr, 1'b0);
        chk("abort_busy_low", busy, 1'b0);
        chk("abort_state_idle", dbg_state, ST_IDLE);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);

        // Recovery after abort
        ack_delay = 0;
        issue(8'h7E, 8'h05, 1'b0, 16'h1000, 16'h0000, 8'h00,
              mk(0, 8'h90, 1, 0, 0, 0, 5'd20, 1, 16'h1005, 0, 0, 0, 4), 0);

        // F5/F3 taken from EA[13]/EA[11] (EA=2800)
        issue_xy(8'h46, 8'h00, 16'h2800, 8'h00,
                 mk(0, 8'h38, 1, 0, 0, 0, 5'd20, 1, 16'h2800, 0, 0, 0, 4));

        repeat (5) @(negedge clk);
        chk("exp_queue_drained", exp_q.size(), 32'd0);
        chk("xy_queue_drained", exp_x_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
